// File: rtl/wb_seq_master_if.sv
// Wishbone classic bus between the sequencing initiator and a responder.
interface wb_seq_master_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_seq_master.sv
// Wishbone classic initiator: runs one read/write command as back-to-back
// single-beat cycles with an incrementing address, reporting each beat on rsp_*.
module wb_seq_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [31:0]     cmd_adr,
  input  logic [31:0]     cmd_dat,
  input  logic [3:0]      cmd_sel,
  input  logic [3:0]      cmd_len,
  output logic            rsp_valid,
  output logic [31:0]     rsp_dat,
  output logic            rsp_err,
  output logic            rsp_last,
  output logic            busy,
  wb_seq_master_if.master wbm
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT);

  logic        rst_meta_q;
  logic        rst_sync_q;

  state_t      state_q,     state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q,      busy_d;
  logic        cyc_q,       cyc_d;
  logic        stb_q,       stb_d;
  logic        we_q,        we_d;
  logic [3:0]  sel_q,       sel_d;
  logic [31:0] adr_q,       adr_d;
  logic [31:0] dat_q,       dat_d;
  logic [3:0]  beat_q,      beat_d;
  logic [3:0]  last_beat_q, last_beat_d;
  logic [15:0] tmo_q,       tmo_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_dat_q,   rsp_dat_d;
  logic        rsp_err_q,   rsp_err_d;
  logic        rsp_last_q,  rsp_last_d;

  logic        tmo_hit;
  logic        is_last;

  // Reset asserts asynchronously but releases only on a clock edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign tmo_hit = ({1'b0, tmo_q} + 17'd1) >= TMO_LIMIT;
  assign is_last = (beat_q == last_beat_q);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    beat_d      = beat_q;
    last_beat_d = last_beat_q;
    tmo_d       = tmo_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = 32'd0;
    rsp_err_d   = 1'b0;
    rsp_last_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = BUS;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          we_d        = cmd_we;
          sel_d       = cmd_sel;
          adr_d       = cmd_adr;
          dat_d       = cmd_dat;
          beat_d      = 4'd0;
          // A length of 0 encodes 16 beats, which the 4-bit wrap gives for free.
          last_beat_d = cmd_len - 4'd1;
          tmo_d       = 16'd0;
        end
      end

      BUS: begin
        if (wbm.wbm_ack_i) begin
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? 32'd0 : wbm.wbm_dat_i;
          rsp_last_d  = is_last;
          tmo_d       = 16'd0;
          beat_d      = beat_q + 4'd1;
          if (is_last) begin
            state_d = DONE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            sel_d   = 4'd0;
            adr_d   = 32'd0;
            dat_d   = 32'd0;
          end else begin
            adr_d = adr_q + 32'd4;
            dat_d = dat_q + 32'd1;
          end
        end else if (tmo_hit) begin
          state_d     = DONE;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = 4'd0;
          adr_d       = 32'd0;
          dat_d       = 32'd0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_last_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge wb_clk_i or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'd0;
      adr_q       <= 32'd0;
      dat_q       <= 32'd0;
      beat_q      <= 4'd0;
      last_beat_q <= 4'd0;
      tmo_q       <= 16'd0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'd0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      beat_q      <= beat_d;
      last_beat_q <= last_beat_d;
      tmo_q       <= tmo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_dat       = rsp_dat_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_last      = rsp_last_q;
  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = stb_q;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_sel_o = sel_q;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_seq_master.sv
// Bench for wb_seq_master: a delay-programmable slave, a command-level reference
// model feeding expectation queues, and a monitor that pops them as the DUT responds.
module tb_wb_seq_master;

  localparam int unsigned TMO = 8;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } beat_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        last;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = 32'd0;
  logic [31:0] cmd_dat = 32'd0;
  logic [3:0]  cmd_sel = 4'd0;
  logic [3:0]  cmd_len = 4'd0;
  logic        rsp_valid;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_last;
  logic        busy;

  int          checks = 0;
  int          failures = 0;
  int unsigned slave_delay = 0;
  bit          stray_en = 1'b0;

  beat_t       exp_beats[$];
  rsp_t        exp_rsps[$];
  int          exp_cyc[$];

  wb_seq_master_if bus();

  wb_seq_master #(.TIMEOUT(TMO)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .cmd_len   (cmd_len),
    .rsp_valid (rsp_valid),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .rsp_last  (rsp_last),
    .busy      (busy),
    .wbm       (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: acks after slave_delay wait cycles, returns adr>>2, may ack stray when idle.
  initial begin : slave
    int cnt;
    cnt = 0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
        if (cnt == int'(slave_delay)) begin
          bus.wbm_ack_i = 1'b1;
          bus.wbm_dat_i = bus.wbm_adr_o >> 2;
          cnt = 0;
        end else begin
          bus.wbm_ack_i = 1'b0;
          bus.wbm_dat_i = $urandom;
          cnt++;
        end
      end else begin
        bus.wbm_ack_i = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.wbm_dat_i = $urandom;
        cnt = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a beat, response or cyc drop.
  initial begin : monitor
    int    cyc_run;
    bit    ready_chk;
    beat_t eb;
    rsp_t  er;
    int    ec;
    cyc_run = 0;
    ready_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc_run = 0;
        ready_chk = 1'b0;
        checkOutput("rsp_in_reset", 32'(rsp_valid), 32'd0);
      end else begin
        if (ready_chk) begin
          checkOutput("ready_after_last", 32'({cmd_ready, busy}), 32'b10);
          ready_chk = 1'b0;
        end
        if (bus.wbm_cyc_o) begin
          cyc_run++;
        end else if (cyc_run != 0) begin
          if (exp_cyc.size() == 0) begin
            checkOutput("cyc_unexpected", 32'(cyc_run), 32'd0);
          end else begin
            ec = exp_cyc.pop_front();
            checkOutput("cyc_cycles", 32'(cyc_run), 32'(ec));
          end
          cyc_run = 0;
        end
        if (bus.wbm_cyc_o && bus.wbm_stb_o && bus.wbm_ack_i) begin
          if (exp_beats.size() == 0) begin
            checkOutput("beat_unexpected", bus.wbm_adr_o, 32'hDEAD_BEEF);
          end else begin
            eb = exp_beats.pop_front();
            checkOutput("beat_adr", bus.wbm_adr_o, eb.adr);
            checkOutput("beat_dat", bus.wbm_dat_o, eb.dat);
            checkOutput("beat_we_sel", 32'({bus.wbm_we_o, bus.wbm_sel_o}), 32'({eb.we, eb.sel}));
          end
        end
        if (rsp_valid) begin
          if (exp_rsps.size() == 0) begin
            checkOutput("rsp_unexpected", 32'(rsp_valid), 32'd0);
          end else begin
            er = exp_rsps.pop_front();
            checkOutput("rsp_dat", rsp_dat, er.dat);
            checkOutput("rsp_err_last", 32'({rsp_err, rsp_last}), 32'({er.err, er.last}));
          end
          if (rsp_last) ready_chk = 1'b1;
        end
      end
    end
  end

  task automatic resetDut();
    int n;
    exp_beats.delete();
    exp_rsps.delete();
    exp_cyc.delete();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_cyc_stb", 32'({bus.wbm_cyc_o, bus.wbm_stb_o}), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("rst_bus_ctl", 32'({bus.wbm_we_o, bus.wbm_sel_o}), 32'd0);
    checkOutput("rst_bus_adr", bus.wbm_adr_o, 32'd0);
    checkOutput("rst_bus_dat", bus.wbm_dat_o, 32'd0);
    checkOutput("rst_rsp", 32'({rsp_valid, rsp_err, rsp_last, busy}), 32'd0);
    checkOutput("rst_rsp_dat", rsp_dat, 32'd0);
    rst_n = 1'b1;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_release_ready", 32'(cmd_ready), 32'd1);
  endtask

  // Issues one command and pushes the model's expected beats, responses and cyc length.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic [3:0] len,
                               input int unsigned delay);
    int    n;
    int    beats;
    beat_t b;
    rsp_t  r;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checkOutput("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      return;
    end
    slave_delay = delay;
    beats = (len == 4'd0) ? 16 : int'(len);
    if (delay >= TMO) begin
      r.dat = 32'd0; r.err = 1'b1; r.last = 1'b1;
      exp_rsps.push_back(r);
      exp_cyc.push_back(int'(TMO));
    end else begin
      for (int k = 0; k < beats; k++) begin
        b.adr = adr + 32'(4 * k);
        b.dat = dat + 32'(k);
        b.we  = we;
        b.sel = sel;
        exp_beats.push_back(b);
        r.dat  = we ? 32'd0 : (b.adr >> 2);
        r.err  = 1'b0;
        r.last = (k == beats - 1);
        exp_rsps.push_back(r);
      end
      exp_cyc.push_back(beats * (int'(delay) + 1));
    end
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_len   = len;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkOutput("accept_cyc_stb", 32'({bus.wbm_cyc_o, bus.wbm_stb_o}), 32'b11);
  endtask

  initial begin : stimulus
    int          n;
    bit          found;
    int unsigned r;
    logic [31:0] adr;
    #3;
    resetDut();

    $display("[TB] directed commands");
    applyStimulus(1'b1, 32'h3000_0000, 32'h0000_1234, 4'hF, 4'd1, 1);
    applyStimulus(1'b0, 32'h3000_0100, 32'h0, 4'hF, 4'd0, 0);
    applyStimulus(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 4'h3, 4'd3, 0);
    stray_en = 1'b1;
    applyStimulus(1'b1, 32'h3000_0040, 32'hA5A5_0000, 4'hF, 4'd2, 100);
    applyStimulus(1'b0, 32'h3000_0080, 32'h0, 4'hC, 4'd2, 7);
    stray_en = 1'b0;

    $display("[TB] reset during a burst");
    applyStimulus(1'b0, 32'h3000_0200, 32'h0, 4'hF, 4'd4, 1);
    found = 1'b0;
    n = 0;
    while (!found && n < 40) begin
      @(posedge clk);
      #1;
      if (bus.wbm_cyc_o && bus.wbm_adr_o == 32'h3000_0204) found = 1'b1;
      n++;
    end
    checkOutput("reach_beat2", 32'(found), 32'd1);
    #2;
    resetDut();
    applyStimulus(1'b1, 32'h3000_0300, 32'h0000_BEEF, 4'h1, 4'd1, 2);

    $display("[TB] random commands");
    for (int i = 0; i < 30; i++) begin
      stray_en = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r < 5)       r = 0;
      else if (r < 7)  r = $urandom_range(1, 3);
      else if (r == 7) r = 7;
      else             r = 100;
      adr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 | ($urandom & 32'h3C)) : ($urandom & 32'hFFFF_FFFC);
      applyStimulus(1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom), 4'($urandom), r);
    end

    n = 0;
    while ((!cmd_ready || exp_rsps.size() != 0 || exp_cyc.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checkOutput("drain_beats", 32'(exp_beats.size()), 32'd0);
    checkOutput("drain_rsps", 32'(exp_rsps.size()), 32'd0);
    checkOutput("drain_cyc", 32'(exp_cyc.size()), 32'd0);
    checkOutput("final_idle", 32'({cmd_ready, busy}), 32'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
